// File: rtl/bubblesort_result_checker.sv
// bubblesort_result_checker: arms on the sorter start, snapshots the sorted
// bus on the done rising edge, then scans it one adjacent pair per cycle. The
// scan counts order violations, records the first one and sums the elements.
//
// Handshake: start_i, abort_i and done_i are level inputs. Only a done rising
// edge seen while ARMED triggers a capture. result_valid_o is a one-cycle
// pulse with no ready. The result outputs hold their value until the next
// report or reset, so a slow consumer may read them at any time.
module bubblesort_result_checker #(
    parameter int  N_ELEM = 49,
    parameter int  ELEM_W = 8,
    localparam int IDX_W  = $clog2(N_ELEM),
    localparam int SUM_W  = ELEM_W + IDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     done_i,
    input  logic [N_ELEM*ELEM_W-1:0] readdata_i,
    output logic                     busy_o,
    output logic                     result_valid_o,
    output logic                     pass_o,
    output logic [IDX_W-1:0]         err_count_o,
    output logic [IDX_W-1:0]         first_err_o,
    output logic [SUM_W-1:0]         checksum_o,
    output logic [1:0]               dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        SCAN   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     done_q;
    logic [N_ELEM*ELEM_W-1:0] snapshot_q;
    logic [IDX_W-1:0]         idx_q;
    logic [IDX_W-1:0]         idx_nxt;
    logic [IDX_W-1:0]         run_err_q;
    logic [IDX_W-1:0]         run_first_q;
    logic [SUM_W-1:0]         run_sum_q;
    logic [ELEM_W-1:0]        elem [N_ELEM];
    logic                     done_edge;
    logic                     last_pair;
    logic                     violation;
    logic                     capture;
    logic                     scan_en;
    logic                     report;

    assign done_edge   = done_i & ~done_q;
    assign idx_nxt     = idx_q + 1'b1;
    assign last_pair   = (idx_q == IDX_W'(N_ELEM - 2));
    assign busy_o      = (state_q == ARMED) | (state_q == SCAN);
    assign dbg_state_o = state_q;

    // Unpack the snapshot into an element array for indexed access.
    always_comb begin
        for (int k = 0; k < N_ELEM; k++) begin
            elem[k] = snapshot_q[k*ELEM_W +: ELEM_W];
        end
    end

    assign violation = (elem[idx_q] > elem[idx_nxt]);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes. Abort wins over a same-cycle done edge.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        scan_en = 1'b0;
        report  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = ARMED;
            end
            ARMED: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (done_edge) begin
                    capture = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                scan_en = 1'b1;
                if (last_pair) state_d = REPORT;
            end
            REPORT: begin
                report  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot capture and running scan accumulators.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q      <= 1'b0;
            snapshot_q  <= '0;
            idx_q       <= '0;
            run_err_q   <= '0;
            run_first_q <= '0;
            run_sum_q   <= '0;
        end else begin
            done_q <= done_i;
            if (capture) begin
                snapshot_q  <= readdata_i;
                idx_q       <= '0;
                run_err_q   <= '0;
                run_first_q <= '0;
                run_sum_q   <= '0;
            end else if (scan_en) begin
                idx_q     <= idx_nxt;
                run_sum_q <= run_sum_q + SUM_W'(elem[idx_q])
                           + (last_pair ? SUM_W'(elem[N_ELEM-1]) : '0);
                if (violation) begin
                    run_err_q <= run_err_q + 1'b1;
                    if (run_err_q == '0) run_first_q <= idx_q;
                end
            end
        end
    end

    // Result registers: loaded once per run in REPORT, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_valid_o <= 1'b0;
            pass_o         <= 1'b0;
            err_count_o    <= '0;
            first_err_o    <= '0;
            checksum_o     <= '0;
        end else begin
            result_valid_o <= report;
            if (report) begin
                pass_o      <= (run_err_q == '0);
                err_count_o <= run_err_q;
                first_err_o <= run_first_q;
                checksum_o  <= run_sum_q;
            end
        end
    end

endmodule
